vram_read_arbiter: RTL

Shares one VRAM read port between several pixel-pipeline requesters (background, sprite and HUD fetchers). It picks one requester per cycle using round-robin order with a bounded burst hold, and drives the VRAM port's enable and address. The VRAM's one-cycle registered read data is routed back to the requester that was granted, with a valid strobe. The block sits between the fetch units and one port of the VRAM instance; that port's enable, address and data connect directly to this block.

---
 rtl/vram_read_arbiter.sv | 82 ++++++++
 1 files changed

// File: rtl/vram_read_arbiter.sv
// Round-robin read arbiter with bounded burst hold in front of one VRAM read port.
// Issues one address per cycle and routes the VRAM's registered data back with a per-requester valid.
module vram_read_arbiter #(
  parameter  int WIDTH     = 12,
  parameter  int DEPTH     = 76800,
  parameter  int REQS      = 4,
  parameter  int MAX_BURST = 4,
  localparam int AWIDTH    = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [REQS-1:0]              req,
  input  logic [REQS-1:0][AWIDTH-1:0]  addr,
  output logic [REQS-1:0]              gnt,
  output logic [REQS-1:0]              rvalid,
  output logic [WIDTH-1:0]             rdata,
  output logic                         vram_en,
  output logic [AWIDTH-1:0]            vram_addr,
  input  logic [WIDTH-1:0]             vram_data
);

  localparam int IDXW = $clog2(REQS);
  localparam int CW   = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0]   MAX_CNT  = CW'(MAX_BURST);
  localparam logic [IDXW-1:0] LAST_RST = IDXW'(REQS - 1);

  logic [IDXW-1:0] last;
  logic [IDXW-1:0] sel;
  logic [IDXW-1:0] scan;
  logic [CW-1:0]   burst_cnt;
  logic            hold;
  logic            found;

  // Handshake: req is held until gnt; gnt marks the address-issue cycle and
  // rvalid follows exactly one cycle later with rdata qualified by it.
  always_comb begin
    sel       = last;
    scan      = last;
    found     = 1'b0;
    gnt       = '0;
    vram_en   = 1'b0;
    vram_addr = '0;
    hold      = rst_n && req[last] && (burst_cnt < MAX_CNT);
    if (hold) begin
      found = 1'b1;
    end else if (rst_n) begin
      // Scan last+1 .. last (wrapping), so a lone requester still wins here.
      for (int k = 1; k <= REQS; k++) begin
        scan = IDXW'((int'(last) + k) % REQS);
        if (!found && req[scan]) begin
          found = 1'b1;
          sel   = scan;
        end
      end
    end
    if (found) begin
      gnt[sel]  = 1'b1;
      vram_en   = 1'b1;
      vram_addr = addr[sel];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last      <= LAST_RST;
      burst_cnt <= '0;
      rvalid    <= '0;
    end else begin
      rvalid <= gnt;
      if (found) begin
        last      <= sel;
        // A hold only happens below MAX_CNT, so the increment saturates there.
        burst_cnt <= hold ? burst_cnt + 1'b1 : CW'(1);
      end else begin
        burst_cnt <= '0;
      end
    end
  end

  assign rdata = vram_data;

endmodule
